// File: rtl/mcb_resp_pkg.sv
// Shared encodings for the MCB port-0 responder: instruction codes, FSM states and the
// command FIFO entry layout.
package mcb_resp_pkg;

   localparam logic [2:0] INSTR_WR    = 3'b000;
   localparam logic [2:0] INSTR_RD    = 3'b001;
   localparam logic [2:0] INSTR_WR_AP = 3'b010;
   localparam logic [2:0] INSTR_RD_AP = 3'b011;

   localparam int unsigned CMD_FIFO_DEPTH = 4;
   localparam int unsigned CMD_W          = 39;

   typedef enum logic [2:0] {
      S_CALIB,
      S_IDLE,
      S_WRITE,
      S_READ,
      S_NOP
   } state_e;

   typedef struct packed {
      logic [2:0]  instr;
      logic [5:0]  bl;
      logic [29:0] addr;
   } cmd_t;

   function automatic logic is_write(input logic [2:0] instr);
      return (instr == INSTR_WR) || (instr == INSTR_WR_AP);
   endfunction

   function automatic logic is_read(input logic [2:0] instr);
      return (instr == INSTR_RD) || (instr == INSTR_RD_AP);
   endfunction

endpackage

// File: rtl/mcb_port_responder_if.sv
// MCB user port 0 signal bundle; master is the initiator, slave is the responder.
interface mcb_port_responder_if;
   logic        calib_done;
   logic        p0_cmd_en;
   logic [2:0]  p0_cmd_instr;
   logic [5:0]  p0_cmd_bl;
   logic [29:0] p0_cmd_byte_addr;
   logic        p0_cmd_full;
   logic        p0_cmd_empty;
   logic        p0_wr_en;
   logic [31:0] p0_wr_data;
   logic [3:0]  p0_wr_mask;
   logic        p0_wr_full;
   logic [6:0]  p0_wr_count;
   logic        p0_rd_en;
   logic [31:0] p0_rd_data;
   logic        p0_rd_empty;
   logic [6:0]  p0_rd_count;
   logic [1:0]  err_flags;

   modport master (
      input  calib_done, p0_cmd_full, p0_cmd_empty, p0_wr_full, p0_wr_count,
             p0_rd_data, p0_rd_empty, p0_rd_count, err_flags,
      output p0_cmd_en, p0_cmd_instr, p0_cmd_bl, p0_cmd_byte_addr,
             p0_wr_en, p0_wr_data, p0_wr_mask, p0_rd_en
   );

   modport slave (
      input  p0_cmd_en, p0_cmd_instr, p0_cmd_bl, p0_cmd_byte_addr,
             p0_wr_en, p0_wr_data, p0_wr_mask, p0_rd_en,
      output calib_done, p0_cmd_full, p0_cmd_empty, p0_wr_full, p0_wr_count,
             p0_rd_data, p0_rd_empty, p0_rd_count, err_flags
   );
endinterface

// File: rtl/mcb_resp_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; Depth must be a power of two.
module mcb_resp_fifo #(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 64
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         push_i,
   input  logic [Width-1:0]             data_i,
   input  logic                         pop_i,
   output logic [Width-1:0]             data_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(Depth+1)-1:0]   count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, rptr_q;
   logic [CntW-1:0]  cnt_q;
   logic             do_push, do_pop;

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
         else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   // Head reads as zero while empty so the read port has a defined reset value.
   assign data_o  = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/mcb_port_responder.sv
// MCB port-0 responder: services queued commands against an internal 32-bit word RAM.
// Define MCB_RESP_MASK_EN to store p0_wr_mask and honour per-byte write masking.
module mcb_port_responder
   import mcb_resp_pkg::*;
#(
   parameter int unsigned ADDR_W          = 10,
   parameter int unsigned CALIB_CYCLES    = 16,
   parameter int unsigned DATA_FIFO_DEPTH = 64
) (
   input logic                 clk,
   input logic                 reset_n,
   mcb_port_responder_if.slave bus
);

   localparam int unsigned CntW    = $clog2(DATA_FIFO_DEPTH + 1);
   localparam int unsigned CmdCntW = $clog2(CMD_FIFO_DEPTH + 1);
`ifdef MCB_RESP_MASK_EN
   localparam int unsigned WrW = 36;
`else
   localparam int unsigned WrW = 32;
`endif

   state_e            state_q, state_d;
   logic [31:0]       cal_cnt_q, cal_cnt_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [5:0]        bl_q, bl_d;
   logic [6:0]        idx_q, idx_d;
   logic [1:0]        err_q, err_d;
   logic              calib_done;

   logic               cmd_push, cmd_pop, cmd_full, cmd_empty;
   logic [CMD_W-1:0]   cmd_din, cmd_dout;
   logic [CmdCntW-1:0] cmd_cnt;
   cmd_t               head;

   logic            wr_push, wr_pop, wr_full, wr_empty;
   logic [WrW-1:0]  wr_din, wr_dout;
   logic [CntW-1:0] wr_cnt;

   logic            rd_full, rd_empty;
   logic [31:0]     rd_dout;
   logic [CntW-1:0] rd_cnt;

   logic [CntW-1:0]   need, rd_free;
   logic              ram_we, rd_issue;
   logic [ADDR_W-1:0] word_addr, rd_addr_q;
   logic              a_vld_q, a_last_q, r_vld_q, r_last_q;
   logic [31:0]       ram_rd_q;
   logic [31:0]       mem [2**ADDR_W];

   assign calib_done = (state_q != S_CALIB);

   assign bus.calib_done   = calib_done;
   assign bus.p0_cmd_full  = cmd_full | ~calib_done;
   assign bus.p0_cmd_empty = cmd_empty;
   assign bus.p0_wr_full   = wr_full | ~calib_done;
   assign bus.p0_wr_count  = 7'(wr_cnt);
   assign bus.p0_rd_data   = rd_dout;
   assign bus.p0_rd_empty  = rd_empty;
   assign bus.p0_rd_count  = 7'(rd_cnt);
   assign bus.err_flags    = err_q;

   assign cmd_push = bus.p0_cmd_en & ~bus.p0_cmd_full;
   assign wr_push  = bus.p0_wr_en & ~bus.p0_wr_full;
   assign cmd_din  = {bus.p0_cmd_instr, bus.p0_cmd_bl, bus.p0_cmd_byte_addr};
   assign head     = cmd_t'(cmd_dout);
`ifdef MCB_RESP_MASK_EN
   assign wr_din   = {bus.p0_wr_mask, bus.p0_wr_data};
`else
   assign wr_din   = bus.p0_wr_data;
   logic unused_mask;
   assign unused_mask = ^bus.p0_wr_mask;
`endif

   logic unused_sig;
   assign unused_sig = ^{cmd_cnt, wr_empty, rd_full, head.addr};

   assign need      = CntW'(head.bl) + 1'b1;
   assign rd_free   = CntW'(DATA_FIFO_DEPTH) - rd_cnt;
   assign word_addr = base_q + ADDR_W'(idx_q);

   assign err_d = err_q | {bus.p0_rd_en & rd_empty,
                           (bus.p0_cmd_en & bus.p0_cmd_full) | (bus.p0_wr_en & bus.p0_wr_full)};

   always_comb begin
      state_d   = state_q;
      cal_cnt_d = cal_cnt_q;
      base_d    = base_q;
      bl_d      = bl_q;
      idx_d     = idx_q;
      cmd_pop   = 1'b0;
      wr_pop    = 1'b0;
      ram_we    = 1'b0;
      rd_issue  = 1'b0;
      unique case (state_q)
         S_CALIB: begin
            if (cal_cnt_q == 32'(CALIB_CYCLES - 1)) state_d = S_IDLE;
            else cal_cnt_d = cal_cnt_q + 32'd1;
         end
         S_IDLE: begin
            if (!cmd_empty) begin
               // The head stays put until its data or read space is present; no reordering.
               if (is_write(head.instr)) begin
                  if (wr_cnt >= need) begin
                     cmd_pop = 1'b1;
                     state_d = S_WRITE;
                  end
               end else if (is_read(head.instr)) begin
                  if (rd_free >= need) begin
                     cmd_pop = 1'b1;
                     state_d = S_READ;
                  end
               end else begin
                  cmd_pop = 1'b1;
                  state_d = S_NOP;
               end
               base_d = head.addr[ADDR_W+1:2];
               bl_d   = head.bl;
               idx_d  = '0;
            end
         end
         S_WRITE: begin
            wr_pop = 1'b1;
            ram_we = 1'b1;
            idx_d  = idx_q + 7'd1;
            if (idx_q == {1'b0, bl_q}) state_d = S_IDLE;
         end
         S_READ: begin
            if (idx_q <= {1'b0, bl_q}) begin
               rd_issue = 1'b1;
               idx_d    = idx_q + 7'd1;
            end
            // Leave once the last word lands in the read FIFO.
            if (r_vld_q && r_last_q) state_d = S_IDLE;
         end
         S_NOP:   state_d = S_IDLE;
         default: state_d = S_CALIB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_CALIB;
         cal_cnt_q <= '0;
         base_q    <= '0;
         bl_q      <= '0;
         idx_q     <= '0;
         err_q     <= '0;
         a_vld_q   <= 1'b0;
         a_last_q  <= 1'b0;
         r_vld_q   <= 1'b0;
         r_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cal_cnt_q <= cal_cnt_d;
         base_q    <= base_d;
         bl_q      <= bl_d;
         idx_q     <= idx_d;
         err_q     <= err_d;
         a_vld_q   <= rd_issue;
         a_last_q  <= rd_issue & (idx_q == {1'b0, bl_q});
         r_vld_q   <= a_vld_q;
         r_last_q  <= a_last_q;
      end
   end

   // Backing RAM is not reset so its contents survive a mid-burst reset.
   always_ff @(posedge clk) begin
      rd_addr_q <= word_addr;
      ram_rd_q  <= mem[rd_addr_q];
`ifdef MCB_RESP_MASK_EN
      for (int b = 0; b < 4; b++) begin
         if (ram_we && reset_n && !wr_dout[32+b]) mem[word_addr][8*b +: 8] <= wr_dout[8*b +: 8];
      end
`else
      if (ram_we && reset_n) mem[word_addr] <= wr_dout;
`endif
   end

   mcb_resp_fifo #(.Width(CMD_W), .Depth(CMD_FIFO_DEPTH)) u_cmd_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (cmd_push),
      .data_i  (cmd_din),
      .pop_i   (cmd_pop),
      .data_o  (cmd_dout),
      .full_o  (cmd_full),
      .empty_o (cmd_empty),
      .count_o (cmd_cnt)
   );

   mcb_resp_fifo #(.Width(WrW), .Depth(DATA_FIFO_DEPTH)) u_wr_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (wr_push),
      .data_i  (wr_din),
      .pop_i   (wr_pop),
      .data_o  (wr_dout),
      .full_o  (wr_full),
      .empty_o (wr_empty),
      .count_o (wr_cnt)
   );

   mcb_resp_fifo #(.Width(32), .Depth(DATA_FIFO_DEPTH)) u_rd_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (r_vld_q),
      .data_i  (ram_rd_q),
      .pop_i   (bus.p0_rd_en),
      .data_o  (rd_dout),
      .full_o  (rd_full),
      .empty_o (rd_empty),
      .count_o (rd_cnt)
   );

endmodule
